// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Handles mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
// Signed operations work on magnitudes and apply the sign in a FIX cycle.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [5:0]       func_i,
   input  logic [WIDTH-1:0] rs_val_i,
   input  logic [WIDTH-1:0] rt_val_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             stall_o,
   output logic [WIDTH-1:0] result_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int unsigned CntW = $clog2(WIDTH);
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   localparam logic [5:0] FuncMfhi = 6'b010000;
   localparam logic [5:0] FuncMthi = 6'b010001;
   localparam logic [5:0] FuncMflo = 6'b010010;
   localparam logic [5:0] FuncMtlo = 6'b010011;

   typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

   state_e state_q, state_d;

   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;     // product, or remainder in low half
   logic [WIDTH-1:0]   a_q, a_d;         // multiplicand / divisor magnitude
   logic [WIDTH-1:0]   b_q, b_d;         // multiplier / dividend, becomes quotient
   logic [WIDTH-1:0]   rs_q, rs_d;       // raw dividend kept for divide-by-zero
   logic               div_q, div_d;
   logic               dz_q, dz_d;
   logic               neg_res_q, neg_res_d;
   logic               neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic             can_accept;
   logic             is_md;
   logic             is_signed;
   logic             is_div;
   logic             rs_neg;
   logic             rt_neg;
   logic [WIDTH-1:0] rs_mag;
   logic [WIDTH-1:0] rt_mag;

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   // Request decode and operand magnitudes.
   assign can_accept = (state_q == StIdle) || (state_q == StDone);
   assign is_md      = (func_i[5:2] == 4'b0110);
   assign is_signed  = ~func_i[0];
   assign is_div     = func_i[1];
   assign rs_neg     = is_signed & rs_val_i[WIDTH-1];
   assign rt_neg     = is_signed & rt_val_i[WIDTH-1];
   assign rs_mag     = rs_neg ? (~rs_val_i + 1'b1) : rs_val_i;
   assign rt_mag     = rt_neg ? (~rt_val_i + 1'b1) : rt_val_i;

   // One iteration of each algorithm, evaluated from current state.
   assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};
   assign div_shift = {acc_q[WIDTH-1:0], b_q[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, a_q};

   // Sign correction applied in FIX.
   assign prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
   assign quo_fix  = neg_res_q ? (~b_q + 1'b1) : b_q;
   assign rem_fix  = neg_rem_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: state_d = (start_i && is_md) ? StRun : StIdle;
         StRun:          state_d = (cnt_q == LastCnt) ? StFix : StRun;
         StFix:          state_d = StDone;
         default:        state_d = StIdle;
      endcase
   end

   // FSM outputs.
   always_comb begin
      busy_o = (state_q == StRun) || (state_q == StFix);
      done_o = (state_q == StDone);
   end

   // Datapath next-state: operand latch, iteration, result write-back.
   always_comb begin
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      a_d       = a_q;
      b_d       = b_q;
      rs_d      = rs_q;
      div_d     = div_q;
      dz_d      = dz_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      if (can_accept && start_i) begin
         if (is_md) begin
            a_d       = is_div ? rt_mag : rs_mag;
            b_d       = is_div ? rs_mag : rt_mag;
            rs_d      = rs_val_i;
            div_d     = is_div;
            dz_d      = is_div && (rt_val_i == '0);
            neg_res_d = rs_neg ^ rt_neg;
            neg_rem_d = rs_neg;
            acc_d     = '0;
            cnt_d     = '0;
         end else if (func_i == FuncMthi) begin
            hi_d = rs_val_i;
         end else if (func_i == FuncMtlo) begin
            lo_d = rs_val_i;
         end
      end else if (state_q == StRun) begin
         if (cnt_q != LastCnt) begin
            cnt_d = cnt_q + 1'b1;
         end
         if (div_q) begin
            // Restore by keeping the shifted value when the trial subtract goes negative.
            acc_d = {{WIDTH{1'b0}}, (div_diff[WIDTH] ? div_shift[WIDTH-1:0]
                                                      : div_diff[WIDTH-1:0])};
            b_d   = {b_q[WIDTH-2:0], ~div_diff[WIDTH]};
         end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            b_d   = {1'b0, b_q[WIDTH-1:1]};
         end
      end else if (state_q == StFix) begin
         if (!div_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
         end else if (dz_q) begin
            hi_d = rs_q;
            lo_d = '1;
         end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         acc_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         rs_q      <= '0;
         div_q     <= 1'b0;
         dz_q      <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         a_q       <= a_d;
         b_q       <= b_d;
         rs_q      <= rs_d;
         div_q     <= div_d;
         dz_q      <= dz_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   // Combinational read port and stall.
   always_comb begin
      stall_o = start_i && busy_o;
      hi_o    = hi_q;
      lo_o    = lo_q;
      if (func_i == FuncMfhi) begin
         result_o = hi_q;
      end else if (func_i == FuncMflo) begin
         result_o = lo_q;
      end else begin
         result_o = '0;
      end
   end

endmodule
